// File: rtl/fft_spectrum_peak.sv
// Power pipeline (re^2+im^2) and per-frame peak search on the FFT result stream.
// Build macro FFT_PEAK_INTERP_EN adds the peak's left/right neighbour powers.
module fft_spectrum_peak #(
    parameter int LOG_N      = 13,
    parameter int DATA_WIDTH = 11,
    parameter int LANE_WIDTH = 16,
    parameter int USER_WIDTH = 24,
    parameter int SKIP_BINS  = 1
) (
    input  logic                      i_aclk,
    input  logic                      i_areset,
    input  logic                      i_axi4s_data_tvalid,
    input  logic [2*LANE_WIDTH-1:0]   i_axi4s_data_tdata,
    input  logic                      i_axi4s_data_tlast,
    input  logic [USER_WIDTH-1:0]     i_axi4s_data_tuser,
    input  logic [LOG_N-1:0]          i_search_hi,
    output logic                      o_pwr_tvalid,
    output logic [2*DATA_WIDTH-1:0]   o_pwr_tdata,
    output logic                      o_pwr_tlast,
    output logic [LOG_N+5:0]          o_pwr_tuser,
    output logic                      o_peak_vld,
    output logic [LOG_N-1:0]          o_peak_idx,
    output logic [2*DATA_WIDTH-1:0]   o_peak_pwr,
    output logic [4:0]                o_peak_exp,
`ifdef FFT_PEAK_INTERP_EN
    output logic [2*DATA_WIDTH-1:0]   o_peak_pwr_l,
    output logic [2*DATA_WIDTH-1:0]   o_peak_pwr_r,
`endif
    output logic [1:0]                o_err,
    output logic [1:0]                o_dbg_state
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = LOG_N + 1;
    localparam logic [CW-1:0] FRAME_LEN = CW'(1) << LOG_N;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    logic                 r_s1_vld, r_s1_last, r_s2_vld, r_s2_last, r_s3_vld, r_s3_last;
    logic signed [PW-1:0] r_s1_re, r_s1_im;
    logic [PW-1:0]        r_s2_re_sq, r_s2_im_sq, r_s3_pwr;
    logic [4:0]           r_s1_exp, r_s2_exp, r_s3_exp;
    logic [LOG_N-1:0]     r_s1_idx, r_s2_idx, r_s3_idx;
    logic signed [PW-1:0] w_re_sq, w_im_sq;
    logic                 w_unused;

    assign w_unused = ^{i_axi4s_data_tdata[LANE_WIDTH-1:DATA_WIDTH],
                        i_axi4s_data_tdata[2*LANE_WIDTH-1:LANE_WIDTH+DATA_WIDTH],
                        i_axi4s_data_tuser[7:5], i_axi4s_data_tuser[USER_WIDTH-1:8+LOG_N]};
    assign w_re_sq = r_s1_re * r_s1_re;
    assign w_im_sq = r_s1_im * r_s1_im;

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            {r_s1_vld, r_s1_last, r_s2_vld, r_s2_last, r_s3_vld, r_s3_last} <= '0;
            r_s1_re <= '0; r_s1_im <= '0; r_s2_re_sq <= '0; r_s2_im_sq <= '0; r_s3_pwr <= '0;
            r_s1_exp <= '0; r_s2_exp <= '0; r_s3_exp <= '0;
            r_s1_idx <= '0; r_s2_idx <= '0; r_s3_idx <= '0;
        end else begin
            r_s1_vld   <= i_axi4s_data_tvalid;
            r_s1_last  <= i_axi4s_data_tvalid & i_axi4s_data_tlast;
            r_s1_re    <= PW'($signed(i_axi4s_data_tdata[DATA_WIDTH-1:0]));
            r_s1_im    <= PW'($signed(i_axi4s_data_tdata[LANE_WIDTH+DATA_WIDTH-1:LANE_WIDTH]));
            r_s1_exp   <= i_axi4s_data_tuser[4:0];
            r_s1_idx   <= i_axi4s_data_tuser[8+LOG_N-1:8];
            r_s2_vld   <= r_s1_vld;
            r_s2_last  <= r_s1_last;
            r_s2_re_sq <= $unsigned(w_re_sq);
            r_s2_im_sq <= $unsigned(w_im_sq);
            r_s2_exp   <= r_s1_exp;
            r_s2_idx   <= r_s1_idx;
            r_s3_vld   <= r_s2_vld;
            r_s3_last  <= r_s2_last;
            r_s3_pwr   <= r_s2_re_sq + r_s2_im_sq;
            r_s3_exp   <= r_s2_exp;
            r_s3_idx   <= r_s2_idx;
        end
    end

    assign o_pwr_tvalid = r_s3_vld;
    assign o_pwr_tdata  = r_s3_pwr;
    assign o_pwr_tlast  = r_s3_last;
    assign o_pwr_tuser  = {r_s3_exp, 1'b0, r_s3_idx};

    // Framing runs on stage-3 beats so the final comparison lands in the closing cycle.
    state_t           r_state, w_state_nxt;
    logic             w_start, w_close, w_new_max, w_in_win, w_idx_err, w_len_err;
    logic [CW-1:0]    r_cnt, w_cnt, w_cnt_inc;
    logic [LOG_N-1:0] r_hi, w_hi, r_best_idx, w_best_idx_nxt, r_peak_idx;
    logic [4:0]       r_exp, w_exp, r_peak_exp;
    logic [PW-1:0]    r_best_pwr, w_best_base, w_best_pwr_nxt, r_peak_pwr;
    logic             r_peak_vld;
    logic [1:0]       r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE:  w_start = r_s3_vld;
            S_RUN:   w_start = 1'b0;
            S_DONE:  begin w_state_nxt = S_IDLE; w_start = r_s3_vld; end
            default: w_state_nxt = S_IDLE;
        endcase
        w_cnt     = w_start ? '0 : r_cnt;
        w_cnt_inc = w_cnt + CW'(1);
        w_close   = r_s3_vld && (r_s3_last || (w_cnt_inc == FRAME_LEN));
        if (w_close)      w_state_nxt = S_DONE;
        else if (w_start) w_state_nxt = S_RUN;
    end

    always_comb begin
        w_hi           = w_start ? i_search_hi : r_hi;
        w_exp          = w_start ? r_s3_exp : r_exp;
        w_best_base    = w_start ? '0 : r_best_pwr;
        w_in_win       = (r_s3_idx >= LOG_N'(SKIP_BINS)) && (r_s3_idx <= w_hi);
        w_new_max      = r_s3_vld && w_in_win && (r_s3_pwr > w_best_base);
        w_best_pwr_nxt = w_new_max ? r_s3_pwr : w_best_base;
        w_best_idx_nxt = w_new_max ? r_s3_idx : (w_start ? '0 : r_best_idx);
        w_idx_err      = r_s3_vld && (r_s3_idx != w_cnt[LOG_N-1:0]);
        w_len_err      = r_s3_vld && (r_s3_last ? (w_cnt_inc != FRAME_LEN) : (w_cnt_inc == FRAME_LEN));
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_state <= S_IDLE; r_cnt <= '0; r_hi <= '0; r_exp <= '0;
            r_best_pwr <= '0; r_best_idx <= '0; r_err <= '0;
            r_peak_vld <= 1'b0; r_peak_idx <= '0; r_peak_pwr <= '0; r_peak_exp <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_peak_vld <= w_close;
            r_err      <= r_err | {w_idx_err, w_len_err};
            if (r_s3_vld) begin
                r_cnt      <= w_cnt_inc;
                r_hi       <= w_hi;
                r_exp      <= w_exp;
                r_best_pwr <= w_best_pwr_nxt;
                r_best_idx <= w_best_idx_nxt;
            end
            if (w_close) begin
                r_peak_idx <= w_best_idx_nxt;
                r_peak_pwr <= w_best_pwr_nxt;
                r_peak_exp <= w_exp;
            end
        end
    end

    assign o_peak_vld  = r_peak_vld;
    assign o_peak_idx  = r_peak_idx;
    assign o_peak_pwr  = r_peak_pwr;
    assign o_peak_exp  = r_peak_exp;
    assign o_err       = r_err;
    assign o_dbg_state = r_state;

`ifdef FFT_PEAK_INTERP_EN
    // Left neighbour is the beat before a new maximum; right is captured from the beat after.
    logic [PW-1:0] r_prev_pwr, r_left, r_right, r_peak_l, r_peak_r, w_left_nxt, w_right_nxt;
    logic          r_arm, w_arm_nxt;

    always_comb begin
        w_left_nxt  = w_start ? '0 : r_left;
        w_right_nxt = w_start ? '0 : r_right;
        w_arm_nxt   = w_start ? 1'b0 : r_arm;
        if (w_new_max) begin
            w_left_nxt  = w_start ? '0 : r_prev_pwr;
            w_right_nxt = '0;
            w_arm_nxt   = 1'b1;
        end else if (r_s3_vld && w_arm_nxt) begin
            w_right_nxt = r_s3_pwr;
            w_arm_nxt   = 1'b0;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_prev_pwr <= '0; r_left <= '0; r_right <= '0; r_arm <= 1'b0;
            r_peak_l <= '0; r_peak_r <= '0;
        end else begin
            if (r_s3_vld) begin
                r_prev_pwr <= r_s3_pwr;
                r_left     <= w_left_nxt;
                r_right    <= w_right_nxt;
                r_arm      <= w_arm_nxt;
            end
            if (w_close) begin
                r_peak_l <= w_left_nxt;
                r_peak_r <= w_right_nxt;
            end
        end
    end

    assign o_peak_pwr_l = r_peak_l;
    assign o_peak_pwr_r = r_peak_r;
`endif
endmodule

// File: tb/tb_fft_spectrum_peak.sv
// Bench for fft_spectrum_peak: randomized frames against a bin-array reference of the peak rules.
module tb_fft_spectrum_peak;
  localparam int N = 8192;
  localparam int SKIP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tvalid, tlast;
  logic [31:0] tdata;
  logic [23:0] tuser;
  logic [12:0] search_hi;
  logic        o_pwr_tvalid, o_pwr_tlast, o_peak_vld;
  logic [21:0] o_pwr_tdata, o_peak_pwr;
  logic [18:0] o_pwr_tuser;
  logic [12:0] o_peak_idx;
  logic [4:0]  o_peak_exp;
  logic [1:0]  o_err, o_dbg_state;
`ifdef FFT_PEAK_INTERP_EN
  logic [21:0] o_peak_pwr_l, o_peak_pwr_r;
`endif

  fft_spectrum_peak dut (
    .i_aclk(clk), .i_areset(rst), .i_axi4s_data_tvalid(tvalid), .i_axi4s_data_tdata(tdata),
    .i_axi4s_data_tlast(tlast), .i_axi4s_data_tuser(tuser), .i_search_hi(search_hi),
    .o_pwr_tvalid(o_pwr_tvalid), .o_pwr_tdata(o_pwr_tdata), .o_pwr_tlast(o_pwr_tlast),
    .o_pwr_tuser(o_pwr_tuser), .o_peak_vld(o_peak_vld), .o_peak_idx(o_peak_idx),
    .o_peak_pwr(o_peak_pwr), .o_peak_exp(o_peak_exp),
`ifdef FFT_PEAK_INTERP_EN
    .o_peak_pwr_l(o_peak_pwr_l), .o_peak_pwr_r(o_peak_pwr_r),
`endif
    .o_err(o_err), .o_dbg_state(o_dbg_state)
  );

  int n_tests = 0;
  int n_fail = 0;
  int n_pulse = 0;
  int re_a[N], im_a[N], idx_a[N], exp_a[N];
  int cur_pwr = 0;
  int cur_u = 0;

  typedef struct { bit v; int p; int u; bit l; } rec_t;
  rec_t pipe_q[$];

  task automatic check(input string tag, input longint obs, input longint expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int pwr_of(input int b);
    return re_a[b] * re_a[b] + im_a[b] * im_a[b];
  endfunction

  // Power stream reference: every input beat reappears exactly three cycles later.
  always @(negedge clk) begin
    rec_t e, c;
    if (o_peak_vld) n_pulse++;
    e = pipe_q.pop_front();
    check("pwr_vld", o_pwr_tvalid, e.v);
    if (e.v) begin
      check("pwr_data", o_pwr_tdata, e.p);
      check("pwr_last", o_pwr_tlast, e.l);
      check("pwr_user", o_pwr_tuser, e.u);
    end
    c.v = tvalid; c.p = cur_pwr; c.u = cur_u; c.l = tlast;
    if (rst) begin
      pipe_q.delete();
      repeat (3) pipe_q.push_back('{v: 1'b0, p: 0, u: 0, l: 1'b0});
    end else begin
      pipe_q.push_back(c);
    end
  end

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_beat(input int b, input bit last);
    logic [4:0] j1, j2;
    logic [2:0] j3, j4;
    j1 = 5'($urandom_range(31)); j2 = 5'($urandom_range(31));
    j3 = 3'($urandom_range(7));  j4 = 3'($urandom_range(7));
    tdata  = {j2, 11'(im_a[b]), j1, 11'(re_a[b])};
    tuser  = {j4, 13'(idx_a[b]), j3, 5'(exp_a[b])};
    tvalid = 1'b1;
    tlast  = last;
    cur_pwr = pwr_of(b);
    cur_u   = (exp_a[b] * 2) * N + (idx_a[b] % N);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int n, input int gap_pct, input bit with_last);
    for (int b = 0; b < n; b++) begin
      while ($urandom_range(99) < gap_pct) idle(1);
      drive_beat(b, with_last && (b == n - 1));
    end
    tvalid = 1'b0;
    tlast = 1'b0;
  endtask

  function automatic void ref_peak(input int n, input int hi, output int pi, output int pp,
                                   output int pl, output int pr);
    int pos;
    pi = 0; pp = 0; pos = -1;
    for (int b = 0; b < n; b++)
      if (idx_a[b] >= SKIP && idx_a[b] <= hi && pwr_of(b) > pp) begin
        pp = pwr_of(b); pi = idx_a[b]; pos = b;
      end
    pl = (pos > 0) ? pwr_of(pos - 1) : 0;
    pr = (pos >= 0 && pos < n - 1) ? pwr_of(pos + 1) : 0;
  endfunction

  task automatic fill_zero(input int e);
    for (int b = 0; b < N; b++) begin re_a[b] = 0; im_a[b] = 0; idx_a[b] = b; exp_a[b] = e; end
  endtask

  task automatic fill_rand(input int amp);
    for (int b = 0; b < N; b++) begin
      re_a[b] = int'($urandom_range(2 * amp)) - amp;
      im_a[b] = int'($urandom_range(2 * amp)) - amp;
      idx_a[b] = b;
      exp_a[b] = int'($urandom_range(31));
    end
  endtask

  task automatic run_frame(input int n, input int gap_pct, input bit with_last, input int hi,
                           input int exp_err);
    int pi, pp, pl, pr, p0;
    bit got;
    ref_peak(n, hi, pi, pp, pl, pr);
    search_hi = 13'(hi);
    p0 = n_pulse;
    send_frame(n, gap_pct, with_last);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = o_peak_vld;
    end
    check("peak_seen", got, 1);
    if (got) begin
      check("peak_idx", o_peak_idx, pi);
      check("peak_pwr", o_peak_pwr, pp);
      check("peak_exp", o_peak_exp, exp_a[0] % 32);
      check("err", o_err, exp_err);
`ifdef FFT_PEAK_INTERP_EN
      check("peak_pwr_l", o_peak_pwr_l, pl);
      check("peak_pwr_r", o_peak_pwr_r, pr);
`endif
    end
    idle(6);
    check("peak_pulses", n_pulse - p0, 1);
    check("peak_hold_idx", o_peak_idx, pi);
  endtask

  task automatic check_zero_outputs();
    check("rst_pwr_vld", o_pwr_tvalid, 0);
    check("rst_pwr_data", o_pwr_tdata, 0);
    check("rst_pwr_user", o_pwr_tuser, 0);
    check("rst_peak_vld", o_peak_vld, 0);
    check("rst_peak_idx", o_peak_idx, 0);
    check("rst_peak_pwr", o_peak_pwr, 0);
    check("rst_peak_exp", o_peak_exp, 0);
    check("rst_err", o_err, 0);
    check("rst_state", o_dbg_state, 0);
  endtask

  initial begin
    int p0;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tuser = '0; search_hi = '0;
    repeat (3) pipe_q.push_back('{v: 1'b0, p: 0, u: 0, l: 1'b0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs();
    rst = 1'b0;
    idle(2);

    // Impulse at bin 100
    fill_zero(9);
    re_a[100] = 500;
    run_frame(N, 0, 1'b1, 4095, 0);

    // DC excluded; blk_exp changes after the first beat
    fill_zero(0);
    for (int b = 0; b < N; b++) exp_a[b] = int'($urandom_range(31));
    exp_a[0] = 3;
    re_a[0] = 1023; im_a[0] = 1023; re_a[7] = 10; im_a[7] = 10;
    run_frame(N, 0, 1'b1, 8191, 0);

    // Tied full-scale corners, without and with tvalid gaps
    fill_zero(17);
    re_a[20] = -1024; im_a[20] = -1024; re_a[30] = -1024; im_a[30] = -1024;
    run_frame(N, 0, 1'b1, 8191, 0);
    run_frame(N, 25, 1'b1, 8191, 0);

    // Short frame then a normal one; length error stays sticky
    fill_rand(1023);
    run_frame(5000, 0, 1'b1, int'($urandom_range(8191, 1)), 1);
    fill_rand(1023);
    run_frame(N, 10, 1'b1, int'($urandom_range(8191, 1)), 1);

    // Index jump 40 -> 42 inside a partial frame, then reset mid-frame
    fill_rand(300);
    re_a[50] = 1000; im_a[50] = 1000;
    for (int b = 41; b < N; b++) idx_a[b] = (b + 1) % N;
    search_hi = 13'd8191;
    p0 = n_pulse;
    send_frame(100, 0, 1'b0);
    idle(6);
    check("skip_err", o_err, 3);
    check("skip_no_pulse", n_pulse - p0, 0);
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    check_zero_outputs();
    rst = 1'b0;
    idle(1);

    // Clean random frame after reset
    fill_rand(500);
    run_frame(N, 5, 1'b1, int'($urandom_range(8191, 1)), 0);

    // No tlast: counter wrap force-closes the frame
    fill_rand(700);
    run_frame(N, 0, 1'b0, int'($urandom_range(8191, 1)), 1);

`ifdef FFT_PEAK_INTERP_EN
    fill_zero(4);
    re_a[99] = 20; re_a[100] = 30; re_a[101] = 10;
    run_frame(N, 0, 1'b1, 8191, 1);
    fill_zero(6);
    re_a[8190] = 5; re_a[8191] = 100;
    run_frame(N, 0, 1'b1, 8191, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_spectrum_peak.md
Name: fft_spectrum_peak

Overview:
- Sits directly downstream of the 8192-point pipeline FFT and consumes its AXI4-Stream result stream (tvalid/tdata/tlast/tuser, no tready).
- Per bin: computes power re²+im² and forwards it with the block exponent.
- Per frame: finds the strongest bin inside a configurable search window and reports it once the frame closes.
- Flags malformed frames (bad length or index sequence) to the control/status logic.

Parameters:
- LOG_N, 13, log2 of FFT length; frame is 2^LOG_N beats.
- DATA_WIDTH, 11, signed width of re/im inside each 16-bit lane.
- LANE_WIDTH, 16, byte-padded lane width of input tdata.
- USER_WIDTH, 24, input tuser width.
- SKIP_BINS, 1, lowest bin index included in the peak search (excludes DC).

Ports:
- i_aclk, in, 1: clock.
- i_areset, in, 1: synchronous active-high reset.
- i_axi4s_data_tvalid, in, 1: FFT output beat valid.
- i_axi4s_data_tdata, in, 2*LANE_WIDTH: re in [LANE_WIDTH-1:0], im in [2*LANE_WIDTH-1:LANE_WIDTH]; each uses its low DATA_WIDTH bits, signed.
- i_axi4s_data_tlast, in, 1: last bin of frame.
- i_axi4s_data_tuser, in, USER_WIDTH: blk_exp in [4:0]; bin index in [8+LOG_N-1:8].
- i_search_hi, in, LOG_N: highest bin included in the peak search; sampled at frame start.
- o_pwr_tvalid, out, 1: power beat valid.
- o_pwr_tdata, out, 2*DATA_WIDTH: unsigned re²+im².
- o_pwr_tlast, out, 1: last power beat of frame.
- o_pwr_tuser, out, LOG_N+6: {2*blk_exp (6b), bin index}.
- o_peak_vld, out, 1: one-cycle pulse, peak result valid.
- o_peak_idx, out, LOG_N: bin index of the maximum.
- o_peak_pwr, out, 2*DATA_WIDTH: power at that bin.
- o_peak_exp, out, 5: blk_exp of that frame.
- o_err, out, 2: sticky flags; [0] length error, [1] index error.

Behaviour:
- All outputs reset to 0. The internal state machine resets to IDLE.
- Reset asserted mid-frame discards partial peak state; the next beat is treated as a frame start.
- There is no backpressure. Every beat with tvalid=1 is consumed, and gaps of tvalid=0 are allowed at any point.
- Power pipeline, fixed 3-cycle latency from input beat to o_pwr_tvalid:
  - Stage 1 registers the sign-extended re/im.
  - Stage 2 squares each.
  - Stage 3 sums.
  - tlast and tuser are delayed alongside the data.
  - Max result: (-1024)²·2 = 2097152, which fits in 22 bits unsigned.
- State machine:
  - IDLE: the first valid beat is frame start. Latch i_search_hi and blk_exp, clear the beat counter, go to RUN.
  - RUN: each valid beat increments the beat counter. A valid beat with tlast goes to DONE.
  - DONE: one cycle. Pulse o_peak_vld, then go to IDLE. A valid beat arriving in DONE is accepted as the next frame start, with the same handling as IDLE.
- Peak search operates on stage-3 power:
  - A bin participates if SKIP_BINS <= index <= latched i_search_hi.
  - Strict greater-than comparison, so on ties the lowest index wins.
  - If no bin participates, report idx 0 and pwr 0.
- Peak outputs hold their value until the next o_peak_vld.
- Length check: tlast with beat count != 2^LOG_N sets o_err[0]. The frame is still closed and the peak still reported.
- Beat counter wrap: a count reaching 2^LOG_N without tlast sets o_err[0] and force-closes the frame as if tlast had arrived.
- Index check: tuser index != beat count sets o_err[1]. Processing continues using the tuser index.
- o_err clears only on reset.
- blk_exp changing mid-frame is ignored; the frame-start value is used.

Optional Feature:
- Macro: FFT_PEAK_INTERP_EN.
- When defined, adds outputs o_peak_pwr_l and o_peak_pwr_r (each 2*DATA_WIDTH): the powers of bins peak-1 and peak+1, for parabolic interpolation.
  - The block keeps the previous bin's power. On a new maximum it captures that value as the left neighbour and arms capture of the next beat as the right neighbour.
  - A neighbour outside the frame, or missing because the peak is the last beat, reads 0.
  - Both neighbours update with o_peak_vld.
- When not defined, these ports and their logic are absent.

Test Plan:
- Impulse spectrum: bin 100 = (re 500, im 0), others 0, i_search_hi=4095 → o_pwr at bin100 = 250000 three cycles after its beat; o_peak_idx=100, o_peak_pwr=250000, one pulse after tlast.
- DC excluded: bin0 = (1023, 1023), bin7 = (10, 10), SKIP_BINS=1 → o_peak_idx=7, o_peak_pwr=200.
- Tie and corner: bins 20 and 30 both (-1024, -1024) → idx=20, pwr=2097152; random tvalid gaps give an identical result.
- Short frame: tlast on beat 5000 → o_err=2'b01, peak reported; next full 8192-beat frame processed normally and o_err stays 01.
- Index skip: tuser index jumps 40→42 → o_err[1]=1. Reset mid-frame → all outputs 0, o_err cleared, next frame clean.
- FFT_PEAK_INTERP_EN: bins 99/100/101 = powers 400/900/100 → o_peak_pwr_l=400, o_peak_pwr_r=100; peak at bin 8191 → o_peak_pwr_r=0.
